// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks.
//   SEG_BLANK  : all segments off (active-low segments)
//   HEX_TO_SEG : nibble -> {dp,g,f,e,d,c,b,a}, active-low, dp off
//   an_drive() : map a one-hot "digit on" mask to pin levels for either anode polarity
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index 15 first: F, E, d, C, b, A, 9 ... 0
    localparam logic [15:0][7:0] HEX_TO_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] an_drive(input logic [7:0] on_mask, input logic act_low);
        return act_low ? ~on_mask : on_mask;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble + decimal point -> active-low segment pattern.
//   nib_i : hex digit 0..F
//   dp_i  : 1 = decimal point lit
//   seg_o : {dp,g,f,e,d,c,b,a}, active-low
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, HEX_TO_SEG[nib_i][6:0]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver.
// New digits are staged in pending registers and only copied to the
// displayed set at a frame boundary, so a frame never mixes old and new data.
//   clk, rst   : clock, asynchronous active-high reset
//   value      : hex digits, digit 0 in value[3:0]
//   dp_in      : decimal point per digit
//   blink_en   : per-digit blink enable
//   blank_lz   : blank leading zeros (live, not staged)
//   load       : stage value/dp_in/blink_en
//   seg        : registered active-low segments {dp,g..a}
//   an         : registered digit enables, polarity from AN_ACT_LOW
//   frame_tick : one-cycle pulse after the slot index wraps to 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_en,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = $clog2(BLINK_FRAMES) + 1;
    localparam logic                ACT_LOW = (AN_ACT_LOW != 0);
    localparam logic [7:0]          AN_OFF8 = an_drive(8'h00, ACT_LOW);
    localparam logic [N_DIGITS-1:0] AN_OFF  = AN_OFF8[N_DIGITS-1:0];

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [N_DIGITS-1:0][3:0]   pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0]        pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [N_DIGITS-1:0]        pend_bl_q, pend_bl_d, disp_bl_q, disp_bl_d;
    logic                       pend_valid_q, pend_valid_d;
    logic [BW-1:0]              bcnt_q, bcnt_d;
    logic                       phase_q, phase_d;
    logic [7:0]                 seg_q, seg_d;
    logic [N_DIGITS-1:0]        an_q, an_d;
    logic                       tick_q, tick_d;

    logic                       slot_end, wrap, guard;
    logic [N_DIGITS-1:0]        lz_blank, an_on;
    logic                       lz_run;
    logic [N_DIGITS-1:0][7:0]   dig_seg;

    assign slot_end = (cnt_q == CW'(REFRESH_DIV - 1));
    assign wrap     = slot_end && (idx_q == IW'(N_DIGITS - 1));
    assign guard    = (cnt_q < CW'(GUARD));

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
        seg7_hex_dec u_dec (
            .nib_i (disp_val_q[g]),
            .dp_i  (disp_dp_q[g]),
            .seg_o (dig_seg[g])
        );
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // while every digit above it (and itself) is zero. Digit 0 is never blanked.
    always_comb begin
        lz_blank = '0;
        lz_run   = blank_lz;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (disp_val_q[i] == 4'h0);
            lz_blank[i] = lz_run;
        end
    end

    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;

        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_bl_d    = pend_bl_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_bl_d    = disp_bl_q;
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;

        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_bl_d    = blink_en;
            pend_valid_d = 1'b1;
        end

        if (wrap) begin
            // A load coinciding with the boundary is newest, so it bypasses pending.
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                disp_bl_d  = blink_en;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
                disp_bl_d  = pend_bl_q;
            end
            pend_valid_d = 1'b0;

            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
            end
        end

        an_on        = '0;
        an_on[idx_q] = 1'b1;
        seg_d        = SEG_BLANK;
        an_d         = AN_OFF;
        if (!guard) begin
            an_d = ACT_LOW ? ~an_on : an_on;
            if (phase_q && disp_bl_q[idx_q])
                seg_d = SEG_BLANK;
            else if (lz_blank[idx_q])
                seg_d = {~disp_dp_q[idx_q], 7'h7F};
            else
                seg_d = dig_seg[idx_q];
        end

        tick_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_bl_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_bl_q    <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_bl_q    <= pend_bl_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_bl_q    <= disp_bl_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            tick_q       <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int G  = 1;
    localparam int BF = 2;
    localparam int NR = N * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    seg7_scan_driver #(
        .N_DIGITS(N), .REFRESH_DIV(R), .GUARD(G), .BLINK_FRAMES(BF), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blink_en(blink_en),
        .blank_lz(blank_lz), .load(load), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct { int k; logic [7:0] seg; logic [3:0] an; logic tick; } exp_t;
    typedef struct { int j; logic [15:0] v; logic [3:0] dp; logic [3:0] bl; } ld_t;

    exp_t sb[$];
    ld_t  loads[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got seg=%h an=%b tick=%b, want seg=%h an=%b tick=%b",
                      name, got[12:5], got[4:1], got[0], exp[12:5], exp[4:1], exp[0]);
    endtask

    // Expected outputs right after the k-th rising edge since reset release.
    // The shown digits are those of the latest load issued before the current
    // frame began; blink phase flips every BF completed frames.
    function automatic exp_t model(input int k, input logic blz);
        exp_t        e;
        int          cnt  = k % R;
        int          slot = (k / R) % N;
        int          f    = k / NR;
        logic [15:0] v    = '0;
        logic [3:0]  dp   = '0;
        logic [3:0]  bl   = '0;
        logic [15:0] hi;
        bit          ph   = ((f / BF) % 2) == 1;
        foreach (loads[i]) begin
            if (loads[i].j < f * NR) begin
                v = loads[i].v; dp = loads[i].dp; bl = loads[i].bl;
            end
        end
        e.k    = k;
        e.tick = ((k % NR) == NR - 1);
        e.seg  = 8'hFF;
        e.an   = 4'hF;
        if (cnt >= G) begin
            e.an = ~(4'b0001 << slot);
            hi   = v >> (4 * slot);
            if (ph && bl[slot])
                e.seg = 8'hFF;
            else if (blz && slot > 0 && hi == 16'h0)
                e.seg = {~dp[slot], 7'h7F};
            else
                e.seg = {~dp[slot], hex_tbl[hi & 16'hF][6:0]};
        end
        return e;
    endfunction

    // Drive inputs for edge k and queue the response expected after it.
    task automatic drive(input int k, input bit do_ld, input logic [15:0] v,
                         input logic [3:0] dp, input logic [3:0] bl, input logic blz);
        ld_t l;
        load     = do_ld;
        value    = v;
        dp_in    = dp;
        blink_en = bl;
        blank_lz = blz;
        if (do_ld) begin
            l.j = k; l.v = v; l.dp = dp; l.bl = bl;
            loads.push_back(l);
        end
        sb.push_back(model(k, blz));
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: return r & 16'h000F;
            1: return r & 16'h00FF;
            2: return r & 16'h0FFF;
            3: return 16'h0000;
            default: return r;
        endcase
    endfunction

    // Scoreboard monitor: compares each registered output against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("out@k%0d", e.k), {seg, an, frame_tick}, {e.seg, e.an, e.tick});
            end
        end
    end

    task automatic run_segment(input int kmax, input bit directed);
        logic        blz = 1'b0;
        bit          ld;
        logic [15:0] v;
        logic [3:0]  dp, bl;
        for (int k = 0; k < kmax; k++) begin
            if (k > 0) @(negedge clk);
            ld = 1'b0;
            v  = 16'($urandom);
            dp = 4'($urandom);
            bl = 4'($urandom);
            if (directed && k < 160) begin
                blz = (k >= 32 && k < 80);
                case (k)
                    2:  begin ld = 1; v = 16'h12AF; dp = 4'h0; bl = 4'h0; end
                    20: begin ld = 1; v = 16'h0050; dp = 4'h0; bl = 4'h0; end
                    47: begin ld = 1; v = 16'h0000; dp = 4'h0; bl = 4'h0; end
                    50: begin ld = 1; v = 16'hFFFF; dp = 4'h0; bl = 4'h0; end
                    53: begin ld = 1; v = 16'h1234; dp = 4'h0; bl = 4'h0; end
                    70: begin ld = 1; v = 16'h9876; dp = 4'b0010; bl = 4'b0001; end
                    default: ;
                endcase
            end else begin
                if (k % NR == 0) blz = 1'($urandom);
                if ($urandom_range(0, 11) == 0) begin
                    ld = 1;
                    v  = rand_val();
                    bl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                end
                if (directed && k == kmax - 1) ld = 1;  // staged but never shown
            end
            drive(k, ld, v, dp, bl, blz);
        end
    endtask

    initial begin
        // Held in reset: outputs parked.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check($sformatf("reset_idle%0d", i), {seg, an, frame_tick}, {8'hFF, 4'hF, 1'b0});
        end
        rst = 1'b0;
        run_segment(16 * 20 + 9, 1'b1);   // next edge would be slot 2 of frame 20

        // Asynchronous reset mid-slot with a load still pending.
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
        #1;
        check("reset_async", {seg, an, frame_tick}, {8'hFF, 4'hF, 1'b0});
        loads.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), {seg, an, frame_tick}, {8'hFF, 4'hF, 1'b0});
        end
        rst = 1'b0;
        run_segment(400, 1'b0);

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
